mul_q16_16: RTL and testbench



---
 rtl/mul_q16_16.sv | 75 +++++++
 tb/tb_mul_q16_16.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/mul_q16_16.sv
`default_nettype none
// ============================================================================
// mul_q16_16 : signed Q16.16 multiplier, combinational result plus a
//              one-cycle registered copy with valid and overflow flags.
// Revision   : 1.0
// ============================================================================
module mul_q16_16 #(
    parameter int WIDTH    = 32,
    parameter int FRAC     = 16,
    parameter int SATURATE = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             in_valid,
    output logic [WIDTH-1:0] val,
    output logic             ovf,
    output logic [WIDTH-1:0] out_val,
    output logic             out_ovf,
    output logic             out_valid
);

    localparam int c_PW   = 2 * WIDTH;
    localparam int c_TOPW = c_PW - (FRAC + WIDTH - 1);

    logic signed [c_PW-1:0]   w_a_ext;
    logic signed [c_PW-1:0]   w_b_ext;
    logic signed [c_PW-1:0]   w_prod;
    logic        [WIDTH-1:0]  w_trunc;
    logic        [c_TOPW-1:0] w_top;
    logic                     w_ovf;
    logic                     w_frac_unused;

    // Sign-extend first so the full 2*WIDTH product is exact.
    assign w_a_ext = {{WIDTH{a[WIDTH-1]}}, a};
    assign w_b_ext = {{WIDTH{b[WIDTH-1]}}, b};
    assign w_prod  = w_a_ext * w_b_ext;

    // Bit-slicing the product is an arithmetic shift: truncation toward -inf.
    assign w_trunc       = w_prod[FRAC+WIDTH-1:FRAC];
    assign w_top         = w_prod[c_PW-1:FRAC+WIDTH-1];
    assign w_ovf         = !((&w_top) || (~|w_top));
    assign w_frac_unused = ^w_prod[FRAC-1:0];

    generate
        if (SATURATE != 0) begin : g_sat
            always_comb begin
                val = w_trunc;
                if (w_ovf) begin
                    val = w_prod[c_PW-1] ? {1'b1, {(WIDTH-1){1'b0}}}
                                         : {1'b0, {(WIDTH-1){1'b1}}};
                end
            end
        end else begin : g_wrap
            assign val = w_trunc;
        end
    endgenerate

    assign ovf = w_ovf;

    always_ff @(posedge clk) begin
        if (rst) begin
            out_val   <= '0;
            out_ovf   <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            out_val   <= val;
            out_ovf   <= ovf;
            out_valid <= in_valid;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mul_q16_16.sv
`default_nettype none
// Bench for mul_q16_16: wrap and saturate instances checked against a 64-bit
// arithmetic model every cycle, plus directed literal vectors.
module tb_mul_q16_16;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [31:0] a;
    logic [31:0] b;

    logic [31:0] val0, val1, oval0, oval1;
    logic        ovf0, ovf1, oovf0, oovf1, ovld0, ovld1;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    mul_q16_16 #(.WIDTH(32), .FRAC(16), .SATURATE(0)) u_wrap (
        .clk(clk), .rst(rst), .a(a), .b(b), .in_valid(in_valid),
        .val(val0), .ovf(ovf0), .out_val(oval0), .out_ovf(oovf0), .out_valid(ovld0)
    );

    mul_q16_16 #(.WIDTH(32), .FRAC(16), .SATURATE(1)) u_sat (
        .clk(clk), .rst(rst), .a(a), .b(b), .in_valid(in_valid),
        .val(val1), .ovf(ovf1), .out_val(oval1), .out_ovf(oovf1), .out_valid(ovld1)
    );

    // Reference model: plain signed 64-bit arithmetic.
    function automatic longint m_prod(input logic [31:0] x, input logic [31:0] y);
        longint sx, sy;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        return sx * sy;
    endfunction

    function automatic logic m_ovf(input longint p);
        longint lim;
        lim = 64'sh0000_8000_0000_0000;
        return (p >= lim) || (p < -lim);
    endfunction

    function automatic logic [31:0] m_val(input longint p, input bit sat);
        longint q;
        if (sat && m_ovf(p))
            return (p < 0) ? 32'h8000_0000 : 32'h7FFF_FFFF;
        q = p >>> 16;
        return q[31:0];
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Expected registered outputs, captured from the model at each rising edge.
    logic [31:0] e_oval0, e_oval1;
    logic        e_oovf, e_ovld;
    bit          started = 1'b0;

    always @(posedge clk) begin
        started <= 1'b1;
        if (rst) begin
            e_oval0 <= 32'h0;
            e_oval1 <= 32'h0;
            e_oovf  <= 1'b0;
            e_ovld  <= 1'b0;
        end else begin
            e_oval0 <= m_val(m_prod(a, b), 1'b0);
            e_oval1 <= m_val(m_prod(a, b), 1'b1);
            e_oovf  <= m_ovf(m_prod(a, b));
            e_ovld  <= in_valid;
        end
    end

    always @(negedge clk) begin
        chk("wrap_val", val0, m_val(m_prod(a, b), 1'b0));
        chk("wrap_ovf", 32'(ovf0), 32'(m_ovf(m_prod(a, b))));
        chk("sat_val",  val1, m_val(m_prod(a, b), 1'b1));
        chk("sat_ovf",  32'(ovf1), 32'(m_ovf(m_prod(a, b))));
        if (started) begin
            chk("wrap_out_val",   oval0, e_oval0);
            chk("wrap_out_ovf",   32'(oovf0), 32'(e_oovf));
            chk("wrap_out_valid", 32'(ovld0), 32'(e_ovld));
            chk("sat_out_val",    oval1, e_oval1);
            chk("sat_out_ovf",    32'(oovf1), 32'(e_oovf));
            chk("sat_out_valid",  32'(ovld1), 32'(e_ovld));
        end
    end

    task automatic apply(input logic [31:0] av, input logic [31:0] bv, input logic iv);
        @(posedge clk);
        #1;
        a        = av;
        b        = bv;
        in_valid = iv;
        #2;
    endtask

    task automatic directed(input string name, input logic [31:0] av, input logic [31:0] bv,
                            input logic [31:0] v0, input logic [31:0] v1, input logic o);
        apply(av, bv, 1'b1);
        chk({name, "_wrap"}, val0, v0);
        chk({name, "_sat"},  val1, v1);
        chk({name, "_ovf"},  32'(ovf0), 32'(o));
    endtask

    function automatic logic [31:0] pick();
        logic [31:0] sp [8];
        logic [31:0] r;
        sp = '{32'h0, 32'h1, 32'hFFFF_FFFF, 32'h8000_0000,
               32'h7FFF_FFFF, 32'h0001_0000, 32'hFFFF_0000, 32'h0080_0000};
        case ($urandom_range(0, 3))
            0:       return sp[$urandom_range(0, 7)];
            1: begin
                r = $urandom;
                return {{14{r[17]}}, r[17:0]};
            end
            default: return $urandom;
        endcase
    endfunction

    initial begin
        rst      = 1'b1;
        in_valid = 1'b0;
        a        = 32'h0;
        b        = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_out_val",   oval0, 32'h0);
        chk("reset_out_ovf",   32'(oovf0), 32'h0);
        chk("reset_out_valid", 32'(ovld0), 32'h0);
        rst = 1'b0;

        directed("two_x_1p5",   32'h0002_0000, 32'h0001_8000, 32'h0003_0000, 32'h0003_0000, 1'b0);
        directed("neg04_sq",    32'hFFFF_999A, 32'hFFFF_999A, 32'h0000_28F5, 32'h0000_28F5, 1'b0);
        directed("neg04_x_06",  32'hFFFF_999A, 32'h0000_999A, 32'hFFFF_C28F, 32'hFFFF_C28F, 1'b0);
        directed("big_256",     32'h0100_0000, 32'h0100_0000, 32'h0000_0000, 32'h7FFF_FFFF, 1'b1);
        directed("neg_big",     32'hFF00_0000, 32'h0100_0000, 32'h0000_0000, 32'h8000_0000, 1'b1);
        directed("min_sq",      32'h8000_0000, 32'h8000_0000, 32'h0000_0000, 32'h7FFF_FFFF, 1'b1);
        directed("zero_a",      32'h0000_0000, 32'h1234_5678, 32'h0000_0000, 32'h0000_0000, 1'b0);
        directed("zero_b",      32'hDEAD_BEEF, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 1'b0);
        directed("neg1_x_neg1", 32'hFFFF_0000, 32'hFFFF_0000, 32'h0001_0000, 32'h0001_0000, 1'b0);

        // Capture 2.0*1.5, then reset the cycle after: the result must be dropped.
        apply(32'h0002_0000, 32'h0001_8000, 1'b1);
        @(posedge clk);
        #1;
        chk("pre_rst_out_val",   oval0, 32'h0003_0000);
        chk("pre_rst_out_valid", 32'(ovld0), 32'h1);
        rst      = 1'b1;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        chk("post_rst_out_val",   oval0, 32'h0);
        chk("post_rst_out_ovf",   32'(oovf0), 32'h0);
        chk("post_rst_out_valid", 32'(ovld0), 32'h0);
        rst = 1'b0;

        for (int i = 0; i < 10000; i++) begin
            @(posedge clk);
            #1;
            a        = pick();
            b        = pick();
            in_valid = 1'($urandom_range(0, 1));
            rst      = ($urandom_range(0, 63) == 0);
        end

        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #6;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
